// File: rtl/serial_tx_mod5.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_mod5
//  Function : MSB-first serial transmitter with a per-frame clear pulse and a
//             running mod-5 tracker for cross-checking a divisibility detector.
//  Revision : 1.0
// ============================================================================
module serial_tx_mod5 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             clr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             exp_div5,
    output logic             done,
    output logic [2:0]       rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_rem;
    logic             r_done;
    logic             w_bit;
    logic             w_accept;
    logic             w_last;
    logic [2:0]       w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        clr          = 1'b0;
        ser_valid    = 1'b0;
        w_bit        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                clr          = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                w_bit     = r_shreg[WIDTH-1];
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Next remainder = (2*r + bit) mod 5, written out as a lookup table.
    always_comb begin
        w_rem_next = 3'd0;
        case (r_rem)
            3'd0:    w_rem_next = w_bit ? 3'd1 : 3'd0;
            3'd1:    w_rem_next = w_bit ? 3'd3 : 3'd2;
            3'd2:    w_rem_next = w_bit ? 3'd0 : 3'd4;
            3'd3:    w_rem_next = w_bit ? 3'd2 : 3'd1;
            3'd4:    w_rem_next = w_bit ? 3'd4 : 3'd3;
            default: w_rem_next = 3'd0;
        endcase
    end

    assign w_accept = load_valid & load_ready;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_rem   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shreg <= load_data;
                r_cnt   <= CNT_W'(WIDTH);
                r_rem   <= 3'd0;
            end else if (r_state == ST_SHIFT) begin
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt - CNT_W'(1);
                r_rem   <= w_rem_next;
            end
        end
    end

    assign ser_out  = w_bit;
    assign exp_div5 = ser_valid && (w_rem_next == 3'd0);
    assign done     = r_done;
    assign rem      = r_rem;

endmodule
`default_nettype wire

// File: doc/serial_tx_mod5.md
# serial_tx_mod5

- Serial transmitter for the divisible-by-5 bit-stream protocol.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Pulses a one-cycle clear ahead of every frame so the receiving divisibility detector starts from remainder 0.
- Tracks the running value mod 5 and drives the per-bit "divisible" result the detector must produce, so the detector can be cross-checked in system.

## Interface

Parameters:
- WIDTH, 8, frame length in bits (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- load_valid  in  1  word available on load_data.
- load_data  in  WIDTH  word to transmit; sampled only at handshake.
- load_ready  out  1  block can accept a word.
- clr  out  1  one-cycle pulse immediately before a frame's first bit.
- ser_out  out  1  serial data bit, MSB first.
- ser_valid  out  1  ser_out carries a frame bit this cycle.
- exp_div5  out  1  1 when the prefix ending with the current ser_out bit is divisible by 5.
- done  out  1  one-cycle pulse in the cycle after the last bit.
- rem  out  3  registered remainder (0–4) of the bits shifted so far.

## Operation

States: IDLE, CLR, SHIFT.

IDLE:
- load_ready=1.
- On load_valid&&load_ready:
  - shreg<=load_data
  - cnt<=WIDTH
  - rem<=0
  - next state CLR.
- Otherwise stay in IDLE; rem holds the previous frame's final remainder.

CLR:
- clr=1, load_ready=0, ser_valid=0, ser_out=0.
- Next state SHIFT unconditionally.

SHIFT:
- ser_valid=1, ser_out=shreg[WIDTH-1].
- exp_div5 = ((2·rem + ser_out) mod 5 == 0), combinational.
- At each edge:
  - rem<=(2·rem+ser_out) mod 5
  - shreg<=shreg<<1
  - cnt<=cnt-1.
- When cnt==1 at the edge: next state IDLE and done<=1 for one cycle.

Remainder update (r, bit→next r):
- 0: 0→0, 1→1
- 1: 0→2, 1→3
- 2: 0→4, 1→0
- 3: 0→1, 1→2
- 4: 0→3, 1→4

Other rules:
- Outside SHIFT: ser_out=0, ser_valid=0, exp_div5=0.
- load_valid is ignored outside IDLE. load_data changes after the handshake have no effect.
- cnt is wide enough to hold WIDTH; no wrap within a frame.

## Timing

- Reset (rst high at an edge):
  - state=IDLE, rem=0, done=0, clr=0, ser_valid=0, ser_out=0, exp_div5=0.
  - load_ready=1 from the first cycle after reset.
  - A handshake in a cycle with rst high is dropped; rst has priority.
- Frame timeline, with the handshake in cycle 0:
  - cycle 1: clr.
  - cycles 2..WIDTH+1: bits.
  - cycle WIDTH+2: done=1, state IDLE, load_ready=1.
- Back-to-back: a word presented in the done cycle is accepted there. Minimum frame period is WIDTH+2 cycles.
- At the done cycle, rem is the final value mod 5. rem==0 means the whole word is divisible by 5.
- rst mid-frame (CLR or SHIFT):
  - abort next cycle; no done pulse.
  - ser_valid=0, rem=0, load_ready=1.
  - the partial word is discarded.
- exp_div5 is valid in the same cycle as its bit. It matches a detector whose output is combinational on the incoming bit.

## Test plan

1. WIDTH=8, load 0x0A:
   - clr in cycle 1.
   - bits 0,0,0,0,1,0,1,0.
   - exp_div5 1,1,1,1,0,0,1,1.
   - done in cycle 10 with rem=0.
2. Load 0xFF:
   - bits all 1.
   - exp_div5 0,0,0,1,0,0,0,1.
   - rem=0 at done.
3. Load 0x07:
   - exp_div5 1,1,1,1,1,0,0,0.
   - rem=2 at done and held in IDLE until the next accept.
4. load_valid held high with 0x05 then 0x06:
   - second word accepted in the done cycle (cycle 10).
   - clr at cycles 1 and 11.
   - second done at cycle 20 with rem=1.
5. rst asserted in the 4th SHIFT cycle:
   - next cycle ser_valid=0, rem=0, load_ready=1.
   - no done pulse.
   - a subsequent 0x0A frame repeats scenario 1 exactly.
6. load_valid pulsed with 0x33 during SHIFT of a 0x0A frame:
   - ignored; the 0x0A bit sequence is unchanged.
   - load_ready stays 0 until done.
